// File: rtl/rv_ifu_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_ifu_if
// Brief    : IFU bus bundle: instruction-memory request/response, execute
//            redirect, and the fetch-to-decode valid/ready channel.
// Revision : 1.0  initial release
// ============================================================================
interface rv_ifu_if #(
   parameter int BW_ADDR = 32
);
   logic               o_ifu_imem_req;
   logic [BW_ADDR-1:0] o_ifu_imem_addr;
   logic               i_ifu_imem_gnt;
   logic               i_ifu_imem_rvalid;
   logic [31:0]        i_ifu_imem_rdata;
   logic               i_ifu_redir;
   logic [BW_ADDR-1:0] i_ifu_redir_pc;
   logic               o_ifu_valid;
   logic               i_ifu_ready;
   logic [BW_ADDR-1:0] o_ifu_pc;
   logic [31:0]        o_ifu_instr;

   // master = the fetch unit, slave = memory / execute / decode environment
   modport master (
      output o_ifu_imem_req, o_ifu_imem_addr, o_ifu_valid, o_ifu_pc, o_ifu_instr,
      input  i_ifu_imem_gnt, i_ifu_imem_rvalid, i_ifu_imem_rdata,
      input  i_ifu_redir, i_ifu_redir_pc, i_ifu_ready
   );

   modport slave (
      input  o_ifu_imem_req, o_ifu_imem_addr, o_ifu_valid, o_ifu_pc, o_ifu_instr,
      output i_ifu_imem_gnt, i_ifu_imem_rvalid, i_ifu_imem_rdata,
      output i_ifu_redir, i_ifu_redir_pc, i_ifu_ready
   );
endinterface
`default_nettype wire

// File: rtl/rv_ifu.sv
`default_nettype none
// ============================================================================
// Module   : rv_ifu
// Brief    : RV32I instruction fetch unit: PC register, credit-based fetch
//            to 1-cycle-latency imem, {pc,instr} queue toward decode.
// Revision : 1.0  initial release
// ============================================================================
module rv_ifu #(
   parameter int                 BW_ADDR  = 32,
   parameter logic [BW_ADDR-1:0] RESET_PC = '0,
   parameter int                 FQ_DEPTH = 2
) (
   input  wire logic i_ifu_clk,
   input  wire logic i_ifu_rst,
   rv_ifu_if.master  bus
);

   localparam int c_PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam int c_CNT_W = $clog2(FQ_DEPTH + 1);
   localparam int c_OCC_W = c_CNT_W + 1;
   localparam logic [BW_ADDR-1:0] c_ALIGN_MASK = ~BW_ADDR'(3);

   logic [BW_ADDR-1:0] r_pc;
   logic               r_inflight;
   logic [BW_ADDR-1:0] r_inflight_pc;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [BW_ADDR-1:0] r_fq_pc    [FQ_DEPTH];
   logic [31:0]        r_fq_instr [FQ_DEPTH];

   logic               w_valid;
   logic               w_pop;
   logic               w_push;
   logic               w_req;
   logic               w_accept;
   logic [c_OCC_W-1:0] w_occ;
   logic [c_CNT_W-1:0] w_count_nxt;
   logic [BW_ADDR-1:0] w_redir_pc;

   function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
      if (p == c_PTR_W'(FQ_DEPTH - 1)) begin
         return '0;
      end
      return p + c_PTR_W'(1);
   endfunction

   assign w_valid    = !i_ifu_rst && (r_count != '0);
   assign w_pop      = w_valid && bus.i_ifu_ready;
   assign w_redir_pc = bus.i_ifu_redir_pc & c_ALIGN_MASK;

   // Credit check: queue entries left after this pop plus the outstanding
   // response must leave room, so every granted fetch has a slot waiting.
   assign w_occ    = c_OCC_W'(r_count) + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
   assign w_req    = !i_ifu_rst && !bus.i_ifu_redir && (w_occ < c_OCC_W'(FQ_DEPTH));
   assign w_accept = w_req && bus.i_ifu_imem_gnt;
   assign w_push   = !i_ifu_rst && bus.i_ifu_imem_rvalid && r_inflight && !bus.i_ifu_redir;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - c_CNT_W'(1);
      end
   end

   always_ff @(posedge i_ifu_clk) begin
      if (i_ifu_rst) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
      end else if (bus.i_ifu_redir) begin
         // Flush wins over any pop or push in the redirect cycle.
         r_pc       <= w_redir_pc;
         r_inflight <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         if (w_accept) begin
            r_pc          <= r_pc + BW_ADDR'(4);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
         end else begin
            r_inflight <= 1'b0;
         end
         if (w_push) begin
            r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         end
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge i_ifu_clk) begin
      if (w_push) begin
         r_fq_pc[r_wr_ptr]    <= r_inflight_pc;
         r_fq_instr[r_wr_ptr] <= bus.i_ifu_imem_rdata;
      end
   end

   assign bus.o_ifu_imem_req  = w_req;
   assign bus.o_ifu_imem_addr = r_pc & c_ALIGN_MASK;
   assign bus.o_ifu_valid     = w_valid;
   assign bus.o_ifu_pc        = w_valid ? r_fq_pc[r_rd_ptr]    : '0;
   assign bus.o_ifu_instr     = w_valid ? r_fq_instr[r_rd_ptr] : '0;

   // Memory must answer every granted fetch exactly one cycle later.
   a_rvalid_after_accept : assert property (
      @(posedge i_ifu_clk) disable iff (i_ifu_rst) r_inflight |-> bus.i_ifu_imem_rvalid
   );

endmodule
`default_nettype wire

// File: doc/rv_ifu.md
Name: rv_ifu

Overview:
Instruction fetch unit for the RV32I pipeline. Owns the architectural PC register and issues word fetches to instruction memory, which has a fixed 1-cycle read latency. Buffers returned instructions with their PCs in a small fetch queue and presents them to decode over a valid/ready handshake. Handles redirects from execute by flushing the queue and any in-flight fetch.

Parameters:
BW_ADDR, 32, PC / instruction address width in bits
RESET_PC, 0, PC value loaded on reset (word aligned)
FQ_DEPTH, 2, fetch queue entries (>= 2)

Ports:
i_ifu_clk  input  1  clock; all state updates on rising edge
i_ifu_rst  input  1  synchronous active-high reset
o_ifu_imem_req  output  1  fetch request valid
o_ifu_imem_addr  output  BW_ADDR  fetch address (= PC register)
i_ifu_imem_gnt  input  1  memory accepts request this cycle
i_ifu_imem_rvalid  input  1  read data valid; exactly 1 cycle after each accepted request
i_ifu_imem_rdata  input  32  instruction word
i_ifu_redir  input  1  redirect (branch/jump taken) from execute
i_ifu_redir_pc  input  BW_ADDR  redirect target
o_ifu_valid  output  1  queue head valid toward decode
i_ifu_ready  input  1  decode accepts head
o_ifu_pc  output  BW_ADDR  PC of head instruction
o_ifu_instr  output  32  head instruction word

Behaviour:
- Reset (sync, i_ifu_rst=1 at clock edge): pc_q=RESET_PC, queue count=0, read/write pointers=0, inflight=0. While i_ifu_rst=1: o_ifu_imem_req=0, o_ifu_valid=0. o_ifu_pc/o_ifu_instr = 0 when the queue is empty. Reset mid-operation discards queue contents and any in-flight response.
- State: pc_q; inflight flag + inflight_pc; circular FIFO of {pc, instr} with count 0..FQ_DEPTH.
- pop = o_ifu_valid & i_ifu_ready. o_ifu_valid = (count != 0).
- Credit: o_ifu_imem_req = !rst & !i_ifu_redir & ((count - pop + inflight) < FQ_DEPTH). Guarantees every response has a slot. Gives 1 instr/cycle sustained with ready held high.
- o_ifu_imem_addr = pc_q, word aligned (bits [1:0] always 0).
- Accept = req & gnt. On accept: pc_q <= pc_q + 4, wrapping modulo 2^BW_ADDR; inflight <= 1; inflight_pc <= pc_q. Otherwise inflight <= 0. Without gnt, pc_q and addr hold stable.
- Response cycle: if i_ifu_imem_rvalid & inflight & !i_ifu_redir, push {inflight_pc, rdata} at the tail.
  - rvalid with inflight=0 is ignored.
  - inflight=1 without rvalid is a protocol error; the slot is abandoned with no push. An SVA assertion flags it.
- Push/pop in the same cycle: both take effect and count is unchanged. Push into an empty queue becomes visible on o_ifu_valid the next cycle (registered FIFO, no bypass).
- Fetch latency: request accepted in cycle N -> pushed at edge ending N+1 -> o_ifu_valid in N+2.
- Redirect (i_ifu_redir=1 in cycle R):
  - No request issued in R.
  - pc_q <= {i_ifu_redir_pc[BW_ADDR-1:2], 2'b00}.
  - Queue flushed (count, pointers <= 0). A pop in R is ignored, and so is any push.
  - inflight <= 0, dropping a response arriving in R.
  - The target is requested in R+1 and is earliest valid to decode in R+3.
- Redirect and reset together: reset wins.
- Back-pressure: with i_ifu_ready=0, the queue fills to FQ_DEPTH and requests stop. The head's pc/instr hold stable while valid & !ready.

Test Plan:
- Reset release, gnt=1, ready=1, imem returns addr-based words -> requests at 0x0,0x4,0x8,... one per cycle; first o_ifu_valid 2 cycles after the first request with pc=0x0; then pc increments by 4 every cycle with no bubbles.
- ready=0 from start -> exactly 2 requests (0x0, 0x4) issued then req=0; head holds pc=0x0; after ready=1, pops 0x0, 0x4 and fetching resumes at 0x8 with no dropped or duplicated PCs.
- gnt toggles 1,0,0,1 -> o_ifu_imem_addr holds across denied cycles; delivered PC sequence stays 0x0,0x4,0x8 contiguous.
- Redirect to 0x103 while queue holds 2 entries and one fetch is in flight -> queue empties next cycle; in-flight response dropped; next request addr=0x100; decode sees pc=0x100 3 cycles after redirect and no stale PCs.
- pc_q near 0xFFFF_FFFC (reach it by redirect) -> next fetch addr wraps to 0x0000_0000.
- Assert i_ifu_rst for 1 cycle mid-stream with full queue -> o_ifu_valid=0 next cycle; a late rvalid is ignored; fetch restarts at RESET_PC.
